// File: rtl/os_ctl_pkg.sv
// Shared types and encodings for the output-stationary array sequencer.
// Control words are {vld, op[1:0], payload}; an all-zero word is idle.
package os_ctl_pkg;

  localparam int unsigned CTL_ADDR_W = 8;

  // Default-width view; modules with a different ADDR_W size their words directly.
  typedef struct packed {
    logic                  vld;
    logic [1:0]            op;
    logic [CTL_ADDR_W-1:0] payload;
  } ctl_word_t;

  localparam logic [1:0] OP_LOAD    = 2'd0;
  localparam logic [1:0] OP_STREAM  = 2'd1;
  localparam logic [1:0] OP_MAC_CLR = 2'd2;
  localparam logic [1:0] OP_MAC     = 2'd3;
  localparam logic [1:0] OP_WB      = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD,
    ST_STREAM,
    ST_WB,
    ST_DONE
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/skew_lane_gen.sv
// One skewed lane: active for OFFSET <= t < OFFSET+n while streaming.
// Lane mode emits STREAM with payload t-OFFSET; PE mode emits MAC_CLR then MAC.
module skew_lane_gen
  import os_ctl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned CNT_W   = 10,
  parameter bit          PE_MODE = 1'b0,
  parameter int unsigned OFFSET  = 0
) (
  input  logic              i_en,
  input  logic [CNT_W-1:0]  i_t,
  input  logic [CNT_W-1:0]  i_n,
  output logic [ADDR_W+2:0] o_word
);

  localparam logic [CNT_W-1:0] OFF = CNT_W'(OFFSET);

  logic [CNT_W-1:0] w_rel;
  logic             w_ge;
  logic             w_active;

  if (OFFSET == 0) begin : g_no_off
    assign w_ge = 1'b1;
  end else begin : g_off
    assign w_ge = (i_t >= OFF);
  end

  assign w_rel    = i_t - OFF;
  assign w_active = i_en && w_ge && (w_rel < i_n);

  always_comb begin
    o_word = '0;
    if (w_active) begin
      if (PE_MODE) begin
        o_word = {1'b1, (w_rel == '0) ? OP_MAC_CLR : OP_MAC, ADDR_W'(0)};
      end else begin
        o_word = {1'b1, OP_STREAM, w_rel[ADDR_W-1:0]};
      end
    end
  end

endmodule

// File: rtl/os_array_sequencer.sv
// Tile sequencer for a ROWS x COLS output-stationary MAC array:
// request -> load n words -> skewed stream/MAC wavefront -> ROWS-cycle writeback.
module os_array_sequencer
  import os_ctl_pkg::*;
#(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 9
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              grant,
  input  logic [LEN_W-1:0]                  n_in,
  output logic                              req,
  output logic                              busy,
  output logic                              done,
  output logic [ROWS-1:0][ADDR_W+2:0]       i_out,
  output logic [COLS-1:0][ADDR_W+2:0]       w_out,
  output logic [ROWS-1:0][COLS-1:0][ADDR_W+2:0] pe_out,
  output logic [COLS-1:0][ADDR_W+2:0]       g_out
);

  localparam int unsigned CW      = ADDR_W + 3;
  localparam int unsigned NMAX    = 2 ** ADDR_W;
  localparam int unsigned CNT_MAX = max_u(NMAX + ROWS + COLS, 2 ** LEN_W);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic             r_req;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_n_clamp;
  logic             w_stream_en;
  logic [CNT_W-1:0] w_wb_idx;

  logic [ROWS-1:0][CW-1:0]           w_i_lane;
  logic [COLS-1:0][CW-1:0]           w_w_lane;
  logic [ROWS-1:0][COLS-1:0][CW-1:0] w_pe_lane;

  // Clamping to 2^ADDR_W keeps every payload index below the wrap point.
  assign w_n_clamp = (CNT_W'(n_in) > CNT_W'(NMAX)) ? CNT_W'(NMAX) : CNT_W'(n_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (grant) begin
            r_req <= 1'b0;
            r_n   <= w_n_clamp;
            r_cnt <= '0;
            if (w_n_clamp == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (r_cnt + CNT_W'(1) == r_n) begin
            r_cnt   <= '0;
            r_state <= ST_STREAM;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STREAM: begin
          if (r_cnt + CNT_W'(1) == r_n + CNT_W'(ROWS + COLS - 2)) begin
            r_cnt   <= '0;
            r_state <= ST_WB;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WB: begin
          if (r_cnt == CNT_W'(ROWS - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (start) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign req  = r_req;
  assign busy = r_busy;
  assign done = r_done;

  assign w_stream_en = (r_state == ST_STREAM);
  assign w_wb_idx    = CNT_W'(ROWS - 1) - r_cnt;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_lane_gen #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W),
      .PE_MODE(1'b0),
      .OFFSET (r)
    ) u_i_lane (
      .i_en  (w_stream_en),
      .i_t   (r_cnt),
      .i_n   (r_n),
      .o_word(w_i_lane[r])
    );
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      skew_lane_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .PE_MODE(1'b1),
        .OFFSET (r + c)
      ) u_pe_lane (
        .i_en  (w_stream_en),
        .i_t   (r_cnt),
        .i_n   (r_n),
        .o_word(w_pe_lane[r][c])
      );
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    skew_lane_gen #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W),
      .PE_MODE(1'b0),
      .OFFSET (c)
    ) u_w_lane (
      .i_en  (w_stream_en),
      .i_t   (r_cnt),
      .i_n   (r_n),
      .o_word(w_w_lane[c])
    );
  end

  // Stream lanes are already idle outside STREAM; LOAD and WB words are overlaid here.
  always_comb begin
    i_out  = w_i_lane;
    w_out  = w_w_lane;
    pe_out = w_pe_lane;
    g_out  = '0;
    if (r_state == ST_LOAD) begin
      for (int r = 0; r < ROWS; r++) i_out[r] = {1'b1, OP_LOAD, r_cnt[ADDR_W-1:0]};
      for (int c = 0; c < COLS; c++) w_out[c] = {1'b1, OP_LOAD, r_cnt[ADDR_W-1:0]};
    end
    if (r_state == ST_WB) begin
      for (int c = 0; c < COLS; c++) g_out[c] = {1'b1, OP_WB, w_wb_idx[ADDR_W-1:0]};
    end
  end

endmodule

// File: doc/os_array_sequencer.md
Name: os_array_sequencer

Overview:
- Parametrised controller for an ROWS x COLS output-stationary systolic MAC array.
- Flow: wins scratchpad access via req/grant, latches the reduction length n, then broadcasts n load words to every input/weight lane.
- Streams skewed read addresses (lane k delayed k cycles) and drives a diagonal MAC wavefront into the PE grid.
- Finishes with a ROWS-cycle writeback of accumulators through the g_out lanes.

Parameters:
- ROWS, 4, PE grid rows / input lanes
- COLS, 4, PE grid columns / weight and writeback lanes
- ADDR_W, 8, control-word payload width (scratchpad address)
- LEN_W, 9, width of n_in

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a new tile; sampled in IDLE and DONE only
- grant  in  1  scratchpad arbiter grant; sampled in REQ only
- n_in  in  LEN_W  reduction length; latched on the REQ->LOAD transition
- req  out  1  scratchpad access request
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- i_out  out  ROWS x CW  per-row input-lane control words
- w_out  out  COLS x CW  per-column weight-lane control words
- pe_out  out  ROWS x COLS x CW  per-PE control words
- g_out  out  COLS x CW  per-column writeback control words

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Control word (CW = 3+ADDR_W bits): {vld, op[1:0], payload[ADDR_W-1:0]}. An idle word is all-zero; never drive X/Z.
- Op encodings:
  - OP_LOAD=0, OP_STREAM=1 (lanes)
  - OP_MAC_CLR=2, OP_MAC=3 (PE)
  - OP_WB=1 (g_out)
- Reset: state=IDLE, n=0, all counters 0; req, busy, done = 0; every word idle.
- Reset asserted mid-operation: the next cycle is IDLE with all outputs idle; the latched n is discarded.
- Outputs are a Moore decode of registered state and counters; there is no combinational path from input to output.
- State machine:
  - IDLE: start=1 -> REQ.
  - REQ: req=1; grant=1 -> latch n = min(n_in, 2^ADDR_W); go to LOAD, or to DONE if n==0. grant=0 -> stay, req held.
  - LOAD: runs n cycles, k=0..n-1. Every i_out and w_out lane = {1,OP_LOAD,k}; PE and g_out words idle.
  - STREAM: runs n+ROWS+COLS-2 cycles, t=0...
    - i_out[r] = {1,OP_STREAM,t-r} when r <= t <= r+n-1, else idle.
    - w_out[c] likewise, using c.
    - pe_out[r][c] = {1,OP_MAC_CLR,0} at t==r+c; {1,OP_MAC,0} for r+c < t <= r+c+n-1; else idle.
  - WB: runs ROWS cycles, j=0..ROWS-1. g_out[c] = {1,OP_WB,ROWS-1-j} for all c; all other words idle.
  - DONE: one cycle, done=1. start=1 -> REQ (back-to-back tile), else IDLE.
- grant outside REQ and start outside IDLE/DONE are ignored.
- Counter arithmetic: counters are sized for max(2^ADDR_W+ROWS+COLS, 2^LEN_W). Payload = index truncated to ADDR_W; the clamp guarantees no wrap.
- Busy duration from grant acceptance: 2n+2ROWS+COLS-2 cycles plus 1 cycle of DONE.

Decomposition:
- Package os_ctl_pkg:
  - ctl_word_t typedef (ADDR_W from a package localparam, overridable via the module param width cast)
  - op constants and the state enum
- One natural sub-module, skew_lane_gen: given t, lane offset and n, emits one lane's word. Instantiated ROWS+COLS times; the PE grid reuses it with offset r+c and MAC_CLR/MAC op selection.

Test Plan:
- Defaults, n_in=3, grant on the first REQ cycle:
  - LOAD is 3 cycles with payloads 0,1,2 on all lanes.
  - In STREAM, i_out[2] is valid at t=2,3,4 with payloads 0,1,2.
  - pe_out[3][3] is MAC_CLR at t=6, then MAC at t=7,8.
  - STREAM lasts 9 cycles, WB lasts 4 cycles with g_out payloads 3,2,1,0, then done pulses.
- grant held low for 5 cycles in REQ -> req stays 1, all words stay idle, LOAD starts the cycle after grant rises.
- n_in=0 -> REQ, then DONE directly; no valid word ever; busy high for exactly 2 cycles.
- n_in=300 with ADDR_W=8 -> n=256; the final LOAD payload is 255, and i_out[0] is last valid at t=255 with payload 255.
- rst pulsed at STREAM t=4 -> the next cycle all outputs are zero in IDLE; a following start/grant with n_in=2 runs cleanly.
- ROWS=2, COLS=8, n_in=1, start held high -> pe_out[1][7] is MAC_CLR at t=8; STREAM lasts 9 cycles; DONE is followed immediately by REQ.
